// File: rtl/btn_pkg.sv
// Shared types and default timing for the push-button event generator.
// Defaults assume a 50 MHz clk.
package btn_pkg;

    typedef enum logic [1:0] {ARM, IDLE, PRESS, REPEAT} btn_state_t;

    localparam int BTN_CNT_W         = 24;
    localparam int BTN_LONG_CYCLES   = 12_500_000;
    localparam int BTN_REPEAT_CYCLES = 5_000_000;
    localparam int BTN_DBL_CYCLES    = 15_000_000;
    localparam bit BTN_ACTIVE_LOW    = 1'b1;

endpackage

// File: rtl/button_event_gen.sv
// Turns a debounced button level into one-cycle press/release/long/repeat events.
// Define BTN_DBLCLICK_EN to add the dbl_pulse output and the double-click window.
//
// state  | meaning
// ARM    | after reset; wait for the button to read released before arming
// IDLE   | released, waiting for a press
// PRESS  | held, counting towards the long-press threshold
// REPEAT | held past long press, emitting auto-repeat pulses
module button_event_gen
    import btn_pkg::*;
#(
    parameter int CNT_W         = BTN_CNT_W,
    parameter int LONG_CYCLES   = BTN_LONG_CYCLES,
    parameter int REPEAT_CYCLES = BTN_REPEAT_CYCLES,
    parameter bit ACTIVE_LOW    = BTN_ACTIVE_LOW,
    parameter int DBL_CYCLES    = BTN_DBL_CYCLES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_db,
    output logic press_pulse,
    output logic release_pulse,
    output logic long_pulse,
    output logic repeat_pulse,
    output logic held
`ifdef BTN_DBLCLICK_EN
    ,
    output logic dbl_pulse
`endif
);

    localparam longint CNT_MAX = (longint'(1) << CNT_W) - 1;
    localparam logic [CNT_W-1:0] LONG_TC   = CNT_W'(LONG_CYCLES - 1);
    localparam logic [CNT_W-1:0] REPEAT_TC = CNT_W'(REPEAT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    if (LONG_CYCLES < 2 || longint'(LONG_CYCLES) > CNT_MAX) begin : g_bad_long
        $error("button_event_gen: LONG_CYCLES out of range");
    end
    if (REPEAT_CYCLES < 2 || longint'(REPEAT_CYCLES) > CNT_MAX) begin : g_bad_repeat
        $error("button_event_gen: REPEAT_CYCLES out of range");
    end
    if (DBL_CYCLES < 2 || longint'(DBL_CYCLES) > CNT_MAX) begin : g_bad_dbl
        $error("button_event_gen: DBL_CYCLES out of range");
    end

    logic             pressed;
    btn_state_t       state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             press_nxt, release_nxt, long_nxt, repeat_nxt, held_nxt;

    assign pressed = btn_db ^ ACTIVE_LOW;

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        press_nxt   = 1'b0;
        release_nxt = 1'b0;
        long_nxt    = 1'b0;
        repeat_nxt  = 1'b0;
        held_nxt    = 1'b0;
        case (state)
            ARM: begin
                if (!pressed) state_nxt = IDLE;
            end
            IDLE: begin
                if (pressed) begin
                    state_nxt = PRESS;
                    cnt_nxt   = '0;
                    press_nxt = 1'b1;
                    held_nxt  = 1'b1;
                end
            end
            PRESS: begin
                // release wins over a terminal count landing on the same edge
                if (!pressed) begin
                    state_nxt   = IDLE;
                    cnt_nxt     = '0;
                    release_nxt = 1'b1;
                end else if (cnt == LONG_TC) begin
                    state_nxt = REPEAT;
                    cnt_nxt   = '0;
                    long_nxt  = 1'b1;
                    held_nxt  = 1'b1;
                end else begin
                    cnt_nxt  = cnt + CNT_ONE;
                    held_nxt = 1'b1;
                end
            end
            REPEAT: begin
                if (!pressed) begin
                    state_nxt   = IDLE;
                    cnt_nxt     = '0;
                    release_nxt = 1'b1;
                end else if (cnt == REPEAT_TC) begin
                    cnt_nxt    = '0;
                    repeat_nxt = 1'b1;
                    held_nxt   = 1'b1;
                end else begin
                    cnt_nxt  = cnt + CNT_ONE;
                    held_nxt = 1'b1;
                end
            end
            default: state_nxt = ARM;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= ARM;
            cnt           <= '0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            long_pulse    <= 1'b0;
            repeat_pulse  <= 1'b0;
            held          <= 1'b0;
        end else begin
            state         <= state_nxt;
            cnt           <= cnt_nxt;
            press_pulse   <= press_nxt;
            release_pulse <= release_nxt;
            long_pulse    <= long_nxt;
            repeat_pulse  <= repeat_nxt;
            held          <= held_nxt;
        end
    end

`ifdef BTN_DBLCLICK_EN
    localparam logic [CNT_W-1:0] DBL_TC = CNT_W'(DBL_CYCLES - 1);

    // Down-counter: non-zero means the double-click window is open.
    logic [CNT_W-1:0] win_cnt, win_nxt;
    logic             dbl_nxt;

    always_comb begin
        win_nxt = win_cnt;
        dbl_nxt = 1'b0;
        if (win_cnt != '0) win_nxt = win_cnt - CNT_ONE;
        if (state == IDLE && pressed) begin
            dbl_nxt = (win_cnt != '0);
            win_nxt = '0;
        end else if (state == PRESS && !pressed) begin
            win_nxt = DBL_TC;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win_cnt   <= '0;
            dbl_pulse <= 1'b0;
        end else begin
            win_cnt   <= win_nxt;
            dbl_pulse <= dbl_nxt;
        end
    end
`endif

endmodule

// File: tb/tb_button_event_gen.sv
// Self-checking bench for button_event_gen: directed scenarios plus random hold/release runs.
// Build with BTN_DBLCLICK_EN defined to also exercise dbl_pulse.
module tb_button_event_gen;

    localparam int LONG = 8;
    localparam int REP  = 4;
    localparam int DBL  = 6;

    logic clk = 1'b0;
    logic rst_n;
    logic btn_db;
    logic press_pulse, release_pulse, long_pulse, repeat_pulse, held;
`ifdef BTN_DBLCLICK_EN
    logic dbl_pulse;
`endif

    button_event_gen #(
        .CNT_W(8), .LONG_CYCLES(LONG), .REPEAT_CYCLES(REP),
        .ACTIVE_LOW(1'b1), .DBL_CYCLES(DBL)
    ) dut (
        .clk(clk), .rst_n(rst_n), .btn_db(btn_db),
        .press_pulse(press_pulse), .release_pulse(release_pulse),
        .long_pulse(long_pulse), .repeat_pulse(repeat_pulse), .held(held)
`ifdef BTN_DBLCLICK_EN
        , .dbl_pulse(dbl_pulse)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Edge counter; the model reads the pre-edge value, the checker the post-edge value.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference model: events follow from how long the button has been held.
    bit armed, down;
    int start, last_short_rel;
    bit e_press, e_rel, e_long, e_rep, e_held, e_dbl;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            armed = 0; down = 0; start = 0; last_short_rel = -1000000;
            {e_press, e_rel, e_long, e_rep, e_held, e_dbl} = '0;
        end else begin
            bit p;
            int h;
            p = ~btn_db;
            {e_press, e_rel, e_long, e_rep, e_held, e_dbl} = '0;
            if (!armed) begin
                if (!p) armed = 1;
            end else if (!down) begin
                if (p) begin
                    down = 1; start = cyc; e_press = 1; e_held = 1;
                    e_dbl = (cyc - last_short_rel) < DBL;
                    last_short_rel = -1000000;
                end
            end else begin
                h = cyc - start;
                if (!p) begin
                    e_rel = 1; down = 0;
                    if (h <= LONG) last_short_rel = cyc;
                end else begin
                    e_held = 1;
                    e_long = (h == LONG);
                    e_rep  = (h > LONG) && ((h - LONG) % REP == 0);
                end
            end
        end
    end

    // Per-cycle compare plus event log for the directed checks.
    int n_press = 0, n_rel = 0, n_long = 0, n_rep = 0, n_held = 0, n_dbl = 0;
    int c_press = 0, c_rel = 0, c_long = 0;
    int rep_q[$];

    always @(negedge clk) begin
        chk("press_pulse", int'(press_pulse), int'(e_press));
        chk("release_pulse", int'(release_pulse), int'(e_rel));
        chk("long_pulse", int'(long_pulse), int'(e_long));
        chk("repeat_pulse", int'(repeat_pulse), int'(e_rep));
        chk("held", int'(held), int'(e_held));
`ifdef BTN_DBLCLICK_EN
        chk("dbl_pulse", int'(dbl_pulse), int'(e_dbl));
        if (dbl_pulse) n_dbl++;
`endif
        if (press_pulse)   begin n_press++; c_press = cyc; end
        if (release_pulse) begin n_rel++;   c_rel = cyc;   end
        if (long_pulse)    begin n_long++;  c_long = cyc;  end
        if (repeat_pulse)  begin n_rep++;   rep_q.push_back(cyc); end
        if (held) n_held++;
    end

    // Each call leaves time at posedge+1.
    task automatic drive(input logic v, input int n);
        repeat (n) begin
            btn_db = v;
            @(posedge clk);
            #1;
        end
    endtask
    task automatic push(input int n); drive(1'b0, n); endtask
    task automatic lift(input int n); drive(1'b1, n); endtask

    function automatic int total_pulses();
        return n_press + n_rel + n_long + n_rep;
    endfunction

    initial begin
        int b, bh, bl, bq, bd;
        rst_n  = 1'b0;
        btn_db = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Button reads pressed out of reset: nothing may fire.
        push(20);
        chk("t1_no_pulse_while_held", total_pulses(), 0);
        chk("t1_held_low", int'(held), 0);
        lift(4);
        chk("t1_no_pulse_after_release", total_pulses(), 0);

        // Three-cycle press.
        b = n_press; bh = n_held; bl = n_long;
        push(3);
        lift(3);
        chk("t2_press_count", n_press - b, 1);
        chk("t2_release_delay", c_rel - c_press, 3);
        chk("t2_held_cycles", n_held - bh, 3);
        chk("t2_no_long", n_long - bl, 0);

        // Long hold with auto-repeat.
        bq = rep_q.size();
        push(22);
        lift(6);
        chk("t3_long_delay", c_long - c_press, LONG);
        chk("t3_repeat_count", rep_q.size() - bq, 3);
        if (rep_q.size() - bq == 3) begin
            chk("t3_repeat1", rep_q[bq]   - c_press, 12);
            chk("t3_repeat2", rep_q[bq+1] - c_press, 16);
            chk("t3_repeat3", rep_q[bq+2] - c_press, 20);
        end
        chk("t3_release_delay", c_rel - c_press, 22);

        // Release on the terminal-count edge.
        bl = n_long;
        push(LONG);
        lift(4);
        chk("t4_no_long", n_long - bl, 0);
        chk("t4_release_delay", c_rel - c_press, LONG);

        // Reset in REPEAT with the button still down.
        push(14);
        #1 rst_n = 1'b0;
        #1 chk("t5_held_in_reset", int'(held), 0);
        @(posedge clk);
        @(posedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
        b = total_pulses();
        push(10);
        chk("t5_silent_while_held", total_pulses() - b, 0);
        lift(3);
        chk("t5_silent_on_release", total_pulses() - b, 0);
        bh = n_press;
        push(2);
        lift(3);
        chk("t5_fresh_press", n_press - bh, 1);

`ifdef BTN_DBLCLICK_EN
        bd = n_dbl;
        push(2); lift(4); push(2);
        chk("t6_dbl_inside", n_dbl - bd, 1);
        lift(DBL); push(2);
        chk("t6_dbl_edge_outside", n_dbl - bd, 1);
        lift(10);
`else
        bd = 0;
`endif

        // Random hold/release runs with occasional resets.
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 29) == 0) begin
                #1 rst_n = 1'b0;
                @(posedge clk);
                #2 rst_n = 1'b1;
                @(posedge clk);
                #1;
            end
            if (i % 2 == 0) push($urandom_range(1, 26));
            else            lift($urandom_range(1, 9));
        end
        lift(10);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
